operand_fetch: RTL and testbench
================================

Name: operand_fetch

Overview:
Issue-side reader of the 2-read/1-write register file. It accepts decoded instructions, drives the file's two read addresses, and bypasses same-cycle writeback data. A per-register busy scoreboard enforces RAW and WAW interlocks. Resolved operands are presented to execute through a registered valid/ready output stage.

Parameters:
DATA_WIDTH, 32, bits per register/operand
ADDRESS_WIDTH, 5, register index width
NUM_REGS, 2**ADDRESS_WIDTH, scoreboard depth

Ports:
clock  input  1  clock, all state on posedge
reset  input  1  asynchronous, active-low reset (asserted at 0)
flush  input  1  synchronous kill of output stage
in_valid  input  1  decoded instruction present
in_ready  output  1  instruction accepted this cycle when in_valid=1
in_rs1  input  ADDRESS_WIDTH  source 1 index
in_rs2  input  ADDRESS_WIDTH  source 2 index
in_rd  input  ADDRESS_WIDTH  destination index
in_rd_we  input  1  instruction writes in_rd
rf_read_addr1  output  ADDRESS_WIDTH  to file read port 1 (= in_rs1, combinational)
rf_read_addr2  output  ADDRESS_WIDTH  to file read port 2 (= in_rs2, combinational)
rf_data1  input  DATA_WIDTH  file read data 1 (combinational)
rf_data2  input  DATA_WIDTH  file read data 2 (combinational)
wb_en  input  1  writeback strobe (same signal driving file write_en)
wb_addr  input  ADDRESS_WIDTH  writeback index
wb_data  input  DATA_WIDTH  writeback data
out_valid  output  1  operands valid
out_ready  input  1  execute accepts
out_op1  output  DATA_WIDTH  resolved operand 1
out_op2  output  DATA_WIDTH  resolved operand 2
out_rd  output  ADDRESS_WIDTH  destination
out_rd_we  output  1  destination write flag

Behaviour:
- Reset (reset=0, async): out_valid=0; out_op1, out_op2, out_rd=0; out_rd_we=0; all busy bits=0. Reset overrides everything, mid-stall included.
- Effective write: wb_hit(r) = wb_en && wb_addr==r && r!=0.
- pending(r) = r!=0 && ((busy[r] && !wb_hit(r)) || (out_valid && out_rd_we && out_rd==r)).
- hazard = pending(in_rs1) || pending(in_rs2) || (in_rd_we && pending(in_rd)).
- in_ready = (!out_valid || out_ready) && !hazard && !flush. Combinational. accept = in_valid && in_ready.
- Operand select per source: r==0 gives 0; else wb_hit(r) gives wb_data; else rf_data. The bypass is mandatory even though the file may already hold the value.
- Output stage, posedge:
  - flush has priority: out_valid<=0, data regs unchanged.
  - Otherwise, on accept: load out_op1, out_op2, out_rd, out_rd_we and set out_valid<=1.
  - Otherwise, when out_valid && out_ready: out_valid<=0.
  - Otherwise hold. Outputs stay stable while out_valid && !out_ready.
- Latency: one cycle from accept to out_valid. Back-to-back independent instructions sustain 1/cycle when out_ready=1.
- Scoreboard:
  - busy[out_rd] is set on the output handshake (out_valid && out_ready && !flush) when out_rd_we && out_rd!=0.
  - busy[wb_addr] is cleared on wb_en.
  - Set and clear of the same index in one cycle: set wins.
  - busy[0] is always 0.
- flush does not touch busy bits. Downstream guarantees one writeback per handed-off writing instruction.
- WAW stall guarantees at most one outstanding writer per register.
- Writeback to r0: ignored by bypass and scoreboard.

Test Plan:
- Reset, then preload the file with r1=0x11, r2=0x22. Issue rs1=1, rs2=2, rd=3, we=1 with out_ready=1. Required: out_op1=0x11, out_op2=0x22 one cycle later, and busy[3] set after the handshake.
- RAW stall. Issue writer rd=3, then reader rs1=3. Required: in_ready=0 until wb_en=1, wb_addr=3, wb_data=0xABCD. Accept occurs in that same cycle with out_op1=0xABCD taken from the bypass.
- rs1=0 with rf_data1 forced to 0xFFFFFFFF, plus wb_en with wb_addr=0. Required: out_op1=0, and no stall from r0.
- Backpressure. Hold out_ready=0 for 3 cycles. Required: out_* stable and in_ready=0. Release, and verify the next instruction is accepted the same cycle.
- Simultaneous set/clear. Handshake a new writer of r5 in the cycle wb clears the old r5 writer. Required: busy[5]=1 afterward.
- flush asserted with out_valid=1. Required: out_valid=0 next cycle, busy unchanged, in_ready=0 during flush. Assert reset mid-stall and check all outputs return to 0 immediately.

Source files
------------

// File: rtl/operand_fetch.sv
// Issue-side operand reader: drives register-file read addresses, bypasses same-cycle
// writeback data, interlocks RAW/WAW hazards via a busy scoreboard, and registers operands.
module operand_fetch #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 5,
    parameter int NUM_REGS      = 2**ADDRESS_WIDTH
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [ADDRESS_WIDTH-1:0] in_rs1,
    input  logic [ADDRESS_WIDTH-1:0] in_rs2,
    input  logic [ADDRESS_WIDTH-1:0] in_rd,
    input  logic                     in_rd_we,
    output logic [ADDRESS_WIDTH-1:0] rf_read_addr1,
    output logic [ADDRESS_WIDTH-1:0] rf_read_addr2,
    input  logic [DATA_WIDTH-1:0]    rf_data1,
    input  logic [DATA_WIDTH-1:0]    rf_data2,
    input  logic                     wb_en,
    input  logic [ADDRESS_WIDTH-1:0] wb_addr,
    input  logic [DATA_WIDTH-1:0]    wb_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    out_op1,
    output logic [DATA_WIDTH-1:0]    out_op2,
    output logic [ADDRESS_WIDTH-1:0] out_rd,
    output logic                     out_rd_we
);

    localparam logic [ADDRESS_WIDTH-1:0] REG_ZERO  = {ADDRESS_WIDTH{1'b0}};
    localparam logic [DATA_WIDTH-1:0]    DATA_ZERO = {DATA_WIDTH{1'b0}};

    logic [NUM_REGS-1:0]      busy_r;
    logic                     out_valid_r;
    logic [DATA_WIDTH-1:0]    out_op1_r;
    logic [DATA_WIDTH-1:0]    out_op2_r;
    logic [ADDRESS_WIDTH-1:0] out_rd_r;
    logic                     out_rd_we_r;

    logic                     hazard_s;
    logic                     in_ready_s;
    logic                     accept_s;
    logic                     handshake_s;
    logic                     busy_set_s;
    logic [DATA_WIDTH-1:0]    op1_s;
    logic [DATA_WIDTH-1:0]    op2_s;

    function automatic logic wb_hit_f(
        input logic [ADDRESS_WIDTH-1:0] r,
        input logic                     en,
        input logic [ADDRESS_WIDTH-1:0] addr
    );
        return en && (addr == r) && (r != REG_ZERO);
    endfunction

    // A register is pending while a writer is in flight downstream (and not retiring
    // right now) or while a writer of it sits in the output stage.
    function automatic logic pending_f(
        input logic [ADDRESS_WIDTH-1:0] r,
        input logic [NUM_REGS-1:0]      busy,
        input logic                     en,
        input logic [ADDRESS_WIDTH-1:0] addr,
        input logic                     ov,
        input logic                     owe,
        input logic [ADDRESS_WIDTH-1:0] ord
    );
        return (r != REG_ZERO) &&
               ((busy[r] && !wb_hit_f(r, en, addr)) || (ov && owe && (ord == r)));
    endfunction

    assign rf_read_addr1 = in_rs1;
    assign rf_read_addr2 = in_rs2;
    assign in_ready      = in_ready_s;
    assign out_valid     = out_valid_r;
    assign out_op1       = out_op1_r;
    assign out_op2       = out_op2_r;
    assign out_rd        = out_rd_r;
    assign out_rd_we     = out_rd_we_r;

    // Hazard detection, handshakes and bypassed operand selection.
    always_comb begin
        hazard_s = pending_f(in_rs1, busy_r, wb_en, wb_addr, out_valid_r, out_rd_we_r, out_rd_r) ||
                   pending_f(in_rs2, busy_r, wb_en, wb_addr, out_valid_r, out_rd_we_r, out_rd_r) ||
                   (in_rd_we &&
                    pending_f(in_rd, busy_r, wb_en, wb_addr, out_valid_r, out_rd_we_r, out_rd_r));
        in_ready_s  = (!out_valid_r || out_ready) && !hazard_s && !flush;
        accept_s    = in_valid && in_ready_s;
        handshake_s = out_valid_r && out_ready && !flush;
        busy_set_s  = handshake_s && out_rd_we_r && (out_rd_r != REG_ZERO);

        if (in_rs1 == REG_ZERO) begin
            op1_s = DATA_ZERO;
        end else if (wb_hit_f(in_rs1, wb_en, wb_addr)) begin
            op1_s = wb_data;
        end else begin
            op1_s = rf_data1;
        end

        if (in_rs2 == REG_ZERO) begin
            op2_s = DATA_ZERO;
        end else if (wb_hit_f(in_rs2, wb_en, wb_addr)) begin
            op2_s = wb_data;
        end else begin
            op2_s = rf_data2;
        end
    end

    // Output stage: flush kills valid only, leaving the data registers as they were.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_valid_r <= 1'b0;
            out_op1_r   <= DATA_ZERO;
            out_op2_r   <= DATA_ZERO;
            out_rd_r    <= REG_ZERO;
            out_rd_we_r <= 1'b0;
        end else if (flush) begin
            out_valid_r <= 1'b0;
        end else if (accept_s) begin
            out_valid_r <= 1'b1;
            out_op1_r   <= op1_s;
            out_op2_r   <= op2_s;
            out_rd_r    <= in_rd;
            out_rd_we_r <= in_rd_we;
        end else if (out_valid_r && out_ready) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    // Busy scoreboard: set on hand-off of a writer, cleared on its writeback; set wins.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            busy_r <= {NUM_REGS{1'b0}};
        end else begin
            busy_r[0] <= 1'b0;
            for (int i = 1; i < NUM_REGS; i++) begin
                if (busy_set_s && (out_rd_r == ADDRESS_WIDTH'(i))) begin
                    busy_r[i] <= 1'b1;
                end else if (wb_en && (wb_addr == ADDRESS_WIDTH'(i))) begin
                    busy_r[i] <= 1'b0;
                end else begin
                    busy_r[i] <= busy_r[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_operand_fetch.sv
// Directed-vector bench for operand_fetch with a simple register-file model.
module tb_operand_fetch;

    logic        clock;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rs1, in_rs2, in_rd;
    logic        in_rd_we;
    logic [4:0]  rf_read_addr1, rf_read_addr2;
    logic [31:0] rf_data1, rf_data2;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_op1, out_op2;
    logic [4:0]  out_rd;
    logic        out_rd_we;

    logic [31:0] rf_mem [32];
    logic        force1;
    int          n_vec;
    int          n_err;

    operand_fetch dut (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_rd_we(in_rd_we),
        .rf_read_addr1(rf_read_addr1), .rf_read_addr2(rf_read_addr2),
        .rf_data1(rf_data1), .rf_data2(rf_data2),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_op1(out_op1), .out_op2(out_op2), .out_rd(out_rd), .out_rd_we(out_rd_we)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Register file model: combinational read, posedge write, r0 hardwired.
    assign rf_data1 = force1 ? 32'hFFFF_FFFF : rf_mem[rf_read_addr1];
    assign rf_data2 = rf_mem[rf_read_addr2];
    always @(posedge clock) begin
        if (wb_en && wb_addr != 5'd0) rf_mem[wb_addr] <= wb_data;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic v, input logic [4:0] s1, input logic [4:0] s2,
                         input logic [4:0] d, input logic we);
        @(negedge clock);
        in_valid = v; in_rs1 = s1; in_rs2 = s2; in_rd = d; in_rd_we = we;
        #1;
    endtask

    task automatic wb(input logic en, input logic [4:0] a, input logic [31:0] d);
        wb_en = en; wb_addr = a; wb_data = d;
        #1;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        for (int i = 0; i < 32; i++) rf_mem[i] = 32'd0;
        rf_mem[1] = 32'h11; rf_mem[2] = 32'h22;
        force1 = 1'b0; reset = 1'b0; flush = 1'b0; out_ready = 1'b1;
        in_valid = 1'b0; in_rs1 = 5'd0; in_rs2 = 5'd0; in_rd = 5'd0; in_rd_we = 1'b0;
        wb_en = 1'b0; wb_addr = 5'd0; wb_data = 32'd0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_op1", out_op1, 32'd0);
        check("rst_op2", out_op2, 32'd0);
        check("rst_rd", {27'd0, out_rd}, 32'd0);
        check("rst_rd_we", {31'd0, out_rd_we}, 32'd0);
        @(negedge clock);
        reset = 1'b1;

        // Basic read of r1/r2 into writer of r3
        issue(1'b1, 5'd1, 5'd2, 5'd3, 1'b1);
        check("a_ready", {31'd0, in_ready}, 32'd1);
        check("a_addr1", {27'd0, rf_read_addr1}, 32'd1);
        tick();
        check("a_valid", {31'd0, out_valid}, 32'd1);
        check("a_op1", out_op1, 32'h11);
        check("a_op2", out_op2, 32'h22);
        check("a_rd", {27'd0, out_rd}, 32'd3);
        check("a_rd_we", {31'd0, out_rd_we}, 32'd1);

        // RAW reader of r3: blocked by output stage, then by busy[3]
        issue(1'b1, 5'd3, 5'd0, 5'd4, 1'b1);
        check("b_ready_stage", {31'd0, in_ready}, 32'd0);
        tick();
        check("b_valid", {31'd0, out_valid}, 32'd0);
        issue(1'b1, 5'd3, 5'd0, 5'd4, 1'b1);
        check("c_ready_busy3", {31'd0, in_ready}, 32'd0);
        tick();
        issue(1'b1, 5'd3, 5'd0, 5'd4, 1'b1);
        wb(1'b1, 5'd3, 32'hABCD);
        check("d_ready_wb", {31'd0, in_ready}, 32'd1);
        tick();
        check("d_valid", {31'd0, out_valid}, 32'd1);
        check("d_op1_bypass", out_op1, 32'hABCD);
        check("d_op2_r0", out_op2, 32'd0);
        check("d_rd", {27'd0, out_rd}, 32'd4);

        // r0 source with garbage file data and a writeback to r0
        issue(1'b1, 5'd0, 5'd1, 5'd0, 1'b0);
        force1 = 1'b1;
        wb(1'b1, 5'd0, 32'h5555);
        check("e_ready_r0", {31'd0, in_ready}, 32'd1);
        tick();
        check("e_op1_r0", out_op1, 32'd0);
        check("e_op2", out_op2, 32'h11);
        check("e_rd_we", {31'd0, out_rd_we}, 32'd0);

        // Backpressure for three cycles
        for (int i = 0; i < 3; i++) begin
            issue(1'b1, 5'd2, 5'd1, 5'd6, 1'b1);
            force1 = 1'b0; out_ready = 1'b0;
            wb(1'b0, 5'd0, 32'd0);
            check("f_ready_bp", {31'd0, in_ready}, 32'd0);
            tick();
            check("f_valid_hold", {31'd0, out_valid}, 32'd1);
            check("f_op1_hold", out_op1, 32'd0);
            check("f_op2_hold", out_op2, 32'h11);
        end
        issue(1'b1, 5'd2, 5'd1, 5'd6, 1'b1);
        out_ready = 1'b1;
        #1;
        check("g_ready_release", {31'd0, in_ready}, 32'd1);
        tick();
        check("g_op1", out_op1, 32'h22);
        check("g_op2", out_op2, 32'h11);
        check("g_rd", {27'd0, out_rd}, 32'd6);

        // Back-to-back writer of r5 while r4 retires
        issue(1'b1, 5'd0, 5'd0, 5'd5, 1'b1);
        wb(1'b1, 5'd4, 32'h44);
        check("h_ready_b2b", {31'd0, in_ready}, 32'd1);
        tick();
        check("h_rd", {27'd0, out_rd}, 32'd5);

        // Hand-off of r5 writer coincides with an r5 writeback: busy must stay set
        issue(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        wb(1'b1, 5'd5, 32'h55);
        tick();
        check("i_valid", {31'd0, out_valid}, 32'd0);
        issue(1'b0, 5'd5, 5'd0, 5'd0, 1'b0);
        wb(1'b0, 5'd0, 32'd0);
        check("j_busy5_set_wins", {31'd0, in_ready}, 32'd0);

        // Retire r5 and accept a reader of r5/r4 in the same cycle
        issue(1'b1, 5'd5, 5'd4, 5'd7, 1'b1);
        wb(1'b1, 5'd5, 32'h66);
        check("k_ready", {31'd0, in_ready}, 32'd1);
        tick();
        check("k_op1_bypass", out_op1, 32'h66);
        check("k_op2", out_op2, 32'h44);

        // Flush with out_valid=1 and execute stalled
        issue(1'b1, 5'd1, 5'd2, 5'd8, 1'b0);
        wb(1'b0, 5'd0, 32'd0);
        out_ready = 1'b0; flush = 1'b1;
        #1;
        check("l_ready_flush", {31'd0, in_ready}, 32'd0);
        tick();
        check("l_valid_flushed", {31'd0, out_valid}, 32'd0);
        check("l_op1_kept", out_op1, 32'h66);
        check("l_rd_kept", {27'd0, out_rd}, 32'd7);

        // busy[6] untouched by flush; reset mid-stall
        issue(1'b1, 5'd6, 5'd0, 5'd0, 1'b0);
        flush = 1'b0; out_ready = 1'b1;
        #1;
        check("m_busy6_stall", {31'd0, in_ready}, 32'd0);
        issue(1'b1, 5'd7, 5'd0, 5'd0, 1'b0);
        check("m_busy7_clear", {31'd0, in_ready}, 32'd1);
        in_rs1 = 5'd6;
        #1;
        reset = 1'b0;
        #1;
        check("n_rst_valid", {31'd0, out_valid}, 32'd0);
        check("n_rst_op1", out_op1, 32'd0);
        check("n_rst_op2", out_op2, 32'd0);
        check("n_rst_rd", {27'd0, out_rd}, 32'd0);
        check("n_rst_rd_we", {31'd0, out_rd_we}, 32'd0);
        check("n_rst_busy_clear", {31'd0, in_ready}, 32'd1);
        issue(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        reset = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
